// File: rtl/ram_march_bist_if.sv
// Port bundle between the March C- BIST initiator, the RAM it tests and system control.
interface ram_march_bist_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_dout;
  logic              busy;
  logic              done;
  logic              pass;
  logic [2:0]        fail_elem;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  modport master (
    input  start, ram_dout,
    output ram_addr, ram_din, ram_wr, busy, done, pass, fail_elem, fail_addr, fail_data
  );

  modport slave (
    output start, ram_dout,
    input  ram_addr, ram_din, ram_wr, busy, done, pass, fail_elem, fail_addr, fail_data
  );
endinterface

// File: rtl/ram_march_bist.sv
// March C- built-in self-test initiator for a single-port synchronous RAM with registered read.
module ram_march_bist #(
  parameter int unsigned       ADDR_W = 10,
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = '0
) (
  input logic              clk,
  input logic              rst_n,
  ram_march_bist_if.master bus
);
  typedef enum logic [2:0] {IDLE, W0, E1, E2, E3, E4, E5, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;
  localparam logic [DATA_W-1:0] BG1  = ~BG;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_wr_q, ram_wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  logic              elem_up;
  logic [DATA_W-1:0] exp_rd;
  logic [DATA_W-1:0] wr_pat;
  logic [2:0]        elem_code;
  state_t            next_elem;
  logic              in_elem;
  logic              at_end;
  logic              mismatch;

  always_comb begin
    elem_up   = 1'b1;
    exp_rd    = BG;
    wr_pat    = BG1;
    elem_code = '0;
    next_elem = DONE;
    case (state_q)
      E1: begin exp_rd = BG;  wr_pat = BG1; elem_code = 3'd1; next_elem = E2; end
      E2: begin exp_rd = BG1; wr_pat = BG;  elem_code = 3'd2; next_elem = E3; end
      E3: begin elem_up = 1'b0; exp_rd = BG;  wr_pat = BG1; elem_code = 3'd3; next_elem = E4; end
      E4: begin elem_up = 1'b0; exp_rd = BG1; wr_pat = BG;  elem_code = 3'd4; next_elem = E5; end
      E5: begin exp_rd = BG;  wr_pat = BG;  elem_code = 3'd5; next_elem = DONE; end
      default: ;
    endcase
  end

  assign in_elem  = (state_q == E1) || (state_q == E2) || (state_q == E3) ||
                    (state_q == E4) || (state_q == E5);
  assign at_end   = elem_up ? (ram_addr_q == LAST) : (ram_addr_q == '0);
  assign mismatch = in_elem && phase_q && (bus.ram_dout != exp_rd);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_wr_d    = ram_wr_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = W0;
          phase_d     = 1'b0;
          ram_addr_d  = '0;
          ram_din_d   = BG;
          ram_wr_d    = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_elem_d = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      W0: begin
        if (ram_addr_q == LAST) begin
          state_d    = E1;
          phase_d    = 1'b0;
          ram_addr_d = '0;
          ram_din_d  = '0;
          ram_wr_d   = 1'b0;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      default: begin
        if (!phase_q) begin
          phase_d   = 1'b1;
          ram_wr_d  = (state_q != E5);
          ram_din_d = wr_pat;
        end else if (mismatch || (at_end && next_elem == DONE)) begin
          state_d    = DONE;
          phase_d    = 1'b0;
          ram_addr_d = '0;
          ram_din_d  = '0;
          ram_wr_d   = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pass_d     = !mismatch;
          if (mismatch) begin
            fail_elem_d = elem_code;
            fail_addr_d = ram_addr_q;
            fail_data_d = bus.ram_dout;
          end
        end else begin
          phase_d   = 1'b0;
          ram_wr_d  = 1'b0;
          ram_din_d = '0;
          if (at_end) begin
            state_d    = next_elem;
            ram_addr_d = (next_elem == E3 || next_elem == E4) ? LAST : '0;
          end else begin
            ram_addr_d = elem_up ? ram_addr_q + ADDR_W'(1) : ram_addr_q - ADDR_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_wr_q    <= ram_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  // Read data only arrives in the CHK cycle itself, so the write it carries is gated off on a mismatch.
  assign bus.ram_wr    = ram_wr_q & ~mismatch;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_elem = fail_elem_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_data = fail_data_q;
endmodule

// File: tb/tb_ram_march_bist.sv
// Scoreboard bench for ram_march_bist driving a behavioural 1Kx8 RAM with stuck-at fault injection.
module tb_ram_march_bist;
  typedef struct {
    bit         pass;
    logic [2:0] elem;
    logic [9:0] addr;
    logic [7:0] data;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   start_cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  int   wr_watch = 0;
  logic done_prev = 1'b0;
  exp_t sb[$];

  logic [7:0] mem [0:1023];
  logic [9:0] f_addr = '0;
  logic [7:0] f_or   = 8'h00;
  logic [7:0] f_and  = 8'hFF;
  logic [9:0] watch_addr = 10'd45;

  ram_march_bist_if #(.ADDR_W(10), .DATA_W(8)) bus ();

  ram_march_bist #(.ADDR_W(10), .DATA_W(8), .BG(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial bus.ram_dout = 8'h00;

  always @(posedge clk) begin
    if (bus.ram_wr) begin
      mem[bus.ram_addr] <= (bus.ram_addr == f_addr) ? ((bus.ram_din | f_or) & f_and) : bus.ram_din;
      if (bus.ram_addr == watch_addr) wr_watch <= wr_watch + 1;
    end else begin
      bus.ram_dout <= mem[bus.ram_addr];
    end
  end

  always @(negedge clk) if (bus.busy) busy_cnt++;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor: every rising done is matched against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        chk("done_pass", bus.pass, e.pass);
        chk("done_fail_elem", bus.fail_elem, e.elem);
        chk("done_fail_addr", bus.fail_addr, e.addr);
        chk("done_fail_data", bus.fail_data, e.data);
        chk("done_latency", cyc - start_cyc, e.lat);
      end
    end
    done_prev = bus.done;
  end

  task automatic pulse_start(input bit rec);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (rec) start_cyc = cyc;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !bus.done; i++) @(negedge clk);
    chk("done_timeout", bus.done, 1);
  endtask

  initial begin
    int nz;
    rst_n = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ram_wr", bus.ram_wr, 0);
    end
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_din", bus.ram_din, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_fail_elem", bus.fail_elem, 0);
    chk("rst_fail_addr", bus.fail_addr, 0);
    chk("rst_fail_data", bus.fail_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fault-free run with two start pulses that must be ignored.
    sb.push_back('{1'b1, 3'd0, 10'd0, 8'h00, 11264});
    busy_cnt = 0;
    pulse_start(1);
    chk("start_busy", bus.busy, 1);
    chk("start_ram_wr", bus.ram_wr, 1);
    chk("start_ram_addr", bus.ram_addr, 0);
    while (cyc - start_cyc < 9) @(negedge clk);
    pulse_start(0);
    while (cyc - start_cyc < 2999) @(negedge clk);
    pulse_start(0);
    wait_done(12000);
    chk("busy_cycles", busy_cnt, 11264);
    nz = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h00) nz++;
    chk("final_contents_nonzero", nz, 0);

    // Stuck-at-1 bit 3 at address 45, started from DONE.
    f_addr = 10'd45; f_or = 8'h08; f_and = 8'hFF;
    watch_addr = 10'd45;
    wr_watch = 0;
    sb.push_back('{1'b0, 3'd1, 10'd45, 8'h08, 1116});
    pulse_start(1);
    chk("restart_done_clear", bus.done, 0);
    chk("restart_pass_clear", bus.pass, 0);
    chk("restart_busy", bus.busy, 1);
    wait_done(2000);
    chk("writes_at_45", wr_watch, 1);

    // Stuck-at-0 bit 7 at address 1023.
    f_addr = 10'd1023; f_or = 8'h00; f_and = 8'h7F;
    sb.push_back('{1'b0, 3'd2, 10'd1023, 8'h7F, 5120});
    pulse_start(1);
    chk("restart_fail_elem_clear", bus.fail_elem, 0);
    chk("restart_fail_addr_clear", bus.fail_addr, 0);
    chk("restart_fail_data_clear", bus.fail_data, 0);
    wait_done(6000);

    // Reset mid-run, then a clean run.
    f_or = 8'h00; f_and = 8'hFF;
    pulse_start(1);
    while (cyc - start_cyc < 500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ram_wr", bus.ram_wr, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{1'b1, 3'd0, 10'd0, 8'h00, 11264});
    pulse_start(1);
    wait_done(12000);

    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_march_bist.md
# ram_march_bist

Built-in self-test initiator for the single-port 1K×8 synchronous RAM. The block drives the RAM's write-enable, address and write-data inputs, samples its read data, and runs a March C- sequence over every location. It reports pass/fail with the first failing address, data and element. It sits between the RAM and system control and owns the RAM port whenever `busy` is high.

## Interface
- `ADDR_W`, 10: RAM address width; DEPTH = 2^ADDR_W.
- `DATA_W`, 8: RAM data width.
- `BG`, 8'h00: background pattern "0"; pattern "1" = ~BG.

- `clk`  in  1  rising-edge clock, shared with RAM.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to run the test.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_din`  out  DATA_W  RAM write data.
- `ram_wr`  out  1  RAM write enable (1 = write at posedge).
- `ram_dout`  in  DATA_W  RAM read data, registered, valid the cycle after a read address is presented with `ram_wr` = 0.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until the next accepted start.
- `pass`  out  1  valid while `done` = 1: no mismatch found.
- `fail_elem`  out  3  element of the first mismatch (1..5), 0 if none.
- `fail_addr`  out  ADDR_W  address of the first mismatch.
- `fail_data`  out  DATA_W  data actually read at the first mismatch.

## Operation
- States: IDLE, W0, E1 (up, R0 W1), E2 (up, R1 W0), E3 (down, R0 W1), E4 (down, R1 W0), E5 (up, R0), DONE.
- In E1–E5, a phase bit selects RD or CHK.
  - RD: `ram_wr` = 0; address is presented.
  - CHK: `ram_dout` is compared with the expected pattern. In E1–E4, the same cycle also drives `ram_wr` = 1 with the new pattern at the same address. In E5, CHK does no write.
- W0: one write per cycle, `ram_din` = BG, addresses 0..DEPTH-1.
- Up elements run addresses 0..DEPTH-1. Down elements run DEPTH-1..0.
- After the last address, the next element starts at 0 (up) or DEPTH-1 (down); the counter never wraps inside an element.
- Transitions:
  - IDLE→W0 on start.
  - W0→E1→E2→E3→E4→E5→DONE, each on completion of its last address.
  - Any CHK mismatch → DONE with `pass` = 0.
  - DONE→W0 on start.
- First mismatch: `fail_elem`, `fail_addr` and `fail_data` are latched, the write in that CHK cycle is suppressed, and the test aborts.
- `start` is ignored while `busy` = 1.
- When not busy: `ram_wr` = 0 and `ram_addr`/`ram_din` hold 0.

## Timing
- All outputs are registered.
- Reset values: `ram_wr` = 0, `ram_addr` = 0, `ram_din` = 0, `busy` = 0, `done` = 0, `pass` = 0, `fail_elem` = 0, `fail_addr` = 0, `fail_data` = 0.
- `rst_n` low mid-run returns the block to IDLE immediately and forces `ram_wr` to 0 asynchronously. RAM contents are left as they are.
- Start latency: `start` is sampled at edge T0. From T0, `busy` = 1, `ram_wr` = 1 and `ram_addr` = 0.
- Cycle budget: W0 takes DEPTH cycles and each of E1–E5 takes 2·DEPTH, for 11·DEPTH cycles in total (11264 at the defaults).
- Completion: `busy` falls, and `done` and `pass` rise, at edge T0 + 11·DEPTH.
- On a fail, `done` rises at the edge ending the failing CHK cycle. `pass` stays 0.
- An accepted start clears `done`, `pass` and the fail fields at the same edge.

## Test plan
All scenarios use a behavioural 1K×8 RAM with registered read and optional fault injection.
- Reset: hold `rst_n` = 0 for 3 cycles → every output is 0, `ram_wr` = 0 throughout.
- Fault-free: pulse `start` → `busy` high for exactly 11264 cycles, then `done` = 1, `pass` = 1, `fail_elem` = 0. Model contents end all 0x00.
- Stuck-at-1 on bit 3 at address 45 → `fail_elem` = 1, `fail_addr` = 45, `fail_data` = 0x08, `pass` = 0. `done` rises during E1, at cycle 1024 + 2·45 + 2 after start. No write occurs at address 45 in the failing cycle.
- Stuck-at-0 on bit 7 at address 1023 → `fail_elem` = 2, `fail_addr` = 1023, `fail_data` = 0x7F, `pass` = 0.
- Reset mid-run: drive `rst_n` low at cycle 500 of a run → `ram_wr` = 0 and `busy` = 0 before the next edge. A following `start` runs to `pass` = 1.
- Start handling:
  - `start` pulsed at cycles 10 and 3000 of a run → both ignored; `done` still occurs at 11264.
  - `start` pulsed while in DONE → `done` clears and a fresh run begins.
